tt_mux_slot_ctrl: RTL and testbench



---
 rtl/tt_mux_pkg.sv | 20 ++
 rtl/tt_mux_ow_sel.sv | 24 ++
 rtl/tt_mux_slot_ctrl.sv | 131 +++++++++++++
 tb/tb_tt_mux_slot_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_mux_pkg.sv
// Shared types and constants for the muxperiment project-slot controller.
// Holds the slot FSM encoding, default bus geometry and the idle-slot index helper.
package tt_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int unsigned IW_DEF      = 18;
    localparam int unsigned OW_DEF      = 24;
    localparam int unsigned RST_BIT_DEF = 1;

    // The "no slot" index is one past the last real slot.
    function automatic int unsigned no_slot_idx(input int unsigned n_proj);
        return n_proj;
    endfunction

endpackage

// File: rtl/tt_mux_ow_sel.sv
// One-of-N combinational selector over the concatenated wrapper output buses.
// Any select value outside 0..N_PROJ-1 yields all zeros.
module tt_mux_ow_sel
    import tt_mux_pkg::*;
#(
    parameter int N_PROJ = 4,
    parameter int OW     = OW_DEF,
    parameter int SEL_W  = $clog2(N_PROJ + 1)
) (
    input  logic [SEL_W-1:0]     sel,
    input  logic [N_PROJ*OW-1:0] ow_i,
    output logic [OW-1:0]        ow_o
);

    always_comb begin
        ow_o = '0;
        for (int k = 0; k < N_PROJ; k++) begin
            if (sel == SEL_W'(k)) begin
                ow_o = ow_i[k*OW +: OW];
            end
        end
    end

endmodule

// File: rtl/tt_mux_slot_ctrl.sv
// Project-slot controller: enables one wrapper at a time, holds its reset for
// RST_HOLD cycles after every selection, then passes traffic with a registered output.
module tt_mux_slot_ctrl
    import tt_mux_pkg::*;
#(
    parameter int N_PROJ   = 4,
    parameter int IW       = IW_DEF,
    parameter int OW       = OW_DEF,
    parameter int RST_BIT  = RST_BIT_DEF,
    parameter int RST_HOLD = 8,
    parameter int SEL_W    = $clog2(N_PROJ + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     sel_idx,
    output logic                 sel_ready,
    input  logic [IW-1:0]        iw_i,
    output logic [IW-1:0]        iw_o,
    output logic [N_PROJ-1:0]    ena_o,
    input  logic [N_PROJ*OW-1:0] ow_i,
    output logic [OW-1:0]        ow_o,
    output logic [SEL_W-1:0]     active_idx,
    output logic                 busy
);

    localparam int              CNT_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [SEL_W-1:0] NO_SLOT  = SEL_W'(no_slot_idx(N_PROJ));
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_HOLD - 1);
    localparam logic [IW-1:0]    RST_MASK = ~(IW'(1) << RST_BIT);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    slot_q, slot_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_PROJ-1:0]   ena_q, ena_d;
    logic [OW-1:0]       ow_q, ow_d;
    logic [OW-1:0]       ow_sel;
    logic                accept;

    tt_mux_ow_sel #(
        .N_PROJ (N_PROJ),
        .OW     (OW),
        .SEL_W  (SEL_W)
    ) u_ow_sel (
        .sel  (slot_q),
        .ow_i (ow_i),
        .ow_o (ow_sel)
    );

    assign sel_ready  = (state_q != ST_HOLD);
    assign busy       = (state_q == ST_HOLD);
    assign accept     = sel_valid && sel_ready;
    assign active_idx = slot_q;
    assign ena_o      = ena_q;
    assign ow_o       = ow_q;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && (sel_idx < NO_SLOT)) begin
                    state_d = ST_HOLD;
                    slot_d  = sel_idx;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Reselecting the running slot still goes through HOLD to re-reset it.
                if (accept) begin
                    if (sel_idx < NO_SLOT) begin
                        state_d = ST_HOLD;
                        slot_d  = sel_idx;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_IDLE;
                        slot_d  = NO_SLOT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = NO_SLOT;
            end
        endcase
    end

    // Enable is decoded from the next state so old and new slot swap in one edge.
    always_comb begin
        ena_d = '0;
        for (int k = 0; k < N_PROJ; k++) begin
            ena_d[k] = (state_d != ST_IDLE) && (slot_d == SEL_W'(k));
        end
    end

    always_comb begin
        ow_d = (state_q == ST_RUN) ? ow_sel : '0;
    end

    always_comb begin
        unique case (state_q)
            ST_HOLD: iw_o = iw_i & RST_MASK;
            ST_RUN:  iw_o = iw_i;
            default: iw_o = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
        if (!rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= NO_SLOT;
            ena_q   <= '0;
            ow_q    <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            ena_q   <= ena_d;
            ow_q    <= ow_d;
        end
    end

endmodule

// File: tb/tb_tt_mux_slot_ctrl.sv
// Bench for tt_mux_slot_ctrl: vector table, directed corner sequences, randomized
// traffic against a slot/hold-countdown model, and an N_PROJ=1 RST_HOLD=1 instance.
module tb_tt_mux_slot_ctrl;

    localparam int NP = 4;
    localparam int RH = 8;
    localparam logic [95:0] OW_TAB = {24'h333333, 24'h222222, 24'h111111, 24'h0F0F0F};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel_valid;
    logic [2:0]  sel_idx;
    logic        sel_ready;
    logic [17:0] iw_i;
    logic [17:0] iw_o;
    logic [3:0]  ena_o;
    logic [95:0] ow_i;
    logic [23:0] ow_o;
    logic [2:0]  active_idx;
    logic        busy;

    logic        s_rst_n;
    logic        s_sel_valid;
    logic [0:0]  s_sel_idx;
    logic        s_sel_ready;
    logic [17:0] s_iw_i;
    logic [17:0] s_iw_o;
    logic [0:0]  s_ena_o;
    logic [23:0] s_ow_i;
    logic [23:0] s_ow_o;
    logic [0:0]  s_active;
    logic        s_busy;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_slot;
    int          m_left;
    logic [23:0] m_ow;

    always #5 clk = ~clk;

    tt_mux_slot_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_valid  (sel_valid),
        .sel_idx    (sel_idx),
        .sel_ready  (sel_ready),
        .iw_i       (iw_i),
        .iw_o       (iw_o),
        .ena_o      (ena_o),
        .ow_i       (ow_i),
        .ow_o       (ow_o),
        .active_idx (active_idx),
        .busy       (busy)
    );

    tt_mux_slot_ctrl #(.N_PROJ(1), .RST_HOLD(1)) dut_small (
        .clk        (clk),
        .rst_n      (s_rst_n),
        .sel_valid  (s_sel_valid),
        .sel_idx    (s_sel_idx),
        .sel_ready  (s_sel_ready),
        .iw_i       (s_iw_i),
        .iw_o       (s_iw_o),
        .ena_o      (s_ena_o),
        .ow_i       (s_ow_i),
        .ow_o       (s_ow_o),
        .active_idx (s_active),
        .busy       (s_busy)
    );

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [2:0]  idx;
        logic [3:0]  ena;
        logic [2:0]  act;
        logic        busy;
        logic        rdy;
        logic [17:0] iwo;
        logic [23:0] ow;
    } vec_t;

    vec_t tab[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Model: m_slot == NP means idle; m_left counts remaining hold cycles.
    task automatic model_edge();
        bit in_hold;
        bit in_run;
        in_hold = (m_slot != NP) && (m_left > 0);
        in_run  = (m_slot != NP) && (m_left == 0);
        if (!rst_n) begin
            m_slot = NP;
            m_left = 0;
            m_ow   = '0;
        end else begin
            m_ow = in_run ? ow_i[m_slot*24 +: 24] : 24'h0;
            if (sel_valid && !in_hold) begin
                if (int'(sel_idx) < NP) begin
                    m_slot = int'(sel_idx);
                    m_left = RH;
                end else begin
                    m_slot = NP;
                    m_left = 0;
                end
            end else if (in_hold) begin
                m_left--;
            end
        end
    endtask

    task automatic check_model();
        bit          idle;
        bit          hold;
        logic [17:0] exp_iw;
        logic [3:0]  exp_ena;
        idle    = (m_slot == NP);
        hold    = !idle && (m_left > 0);
        exp_ena = idle ? 4'b0 : 4'(1 << m_slot);
        exp_iw  = idle ? 18'h0 : (hold ? (iw_i & ~18'h2) : iw_i);
        chk("m_ready",  32'(sel_ready),  32'(!hold));
        chk("m_busy",   32'(busy),       32'(hold));
        chk("m_ena",    32'(ena_o),      32'(exp_ena));
        chk("m_active", 32'(active_idx), 32'(m_slot));
        chk("m_iw_o",   32'(iw_o),       32'(exp_iw));
        chk("m_ow_o",   32'(ow_o),       32'(m_ow));
        chk("m_onehot", 32'($countones(ena_o) <= 1), 32'(1));
    endtask

    task automatic cyc();
        model_edge();
        edge1();
        check_model();
    endtask

    initial begin
        rst_n = 1'b0; sel_valid = 1'b0; sel_idx = '0;
        iw_i = 18'h3FFFF; ow_i = OW_TAB;
        s_rst_n = 1'b0; s_sel_valid = 1'b0; s_sel_idx = '0;
        s_iw_i = 18'h3FFFF; s_ow_i = 24'hABCDEF;
        m_slot = NP; m_left = 0; m_ow = '0;

        //        rst   vld   idx   ena      act   busy  rdy   iw_o       ow_o
        tab[0]  = '{1'b0, 1'b0, 3'd0, 4'b0000, 3'd4, 1'b0, 1'b1, 18'h00000, 24'h000000};
        tab[1]  = '{1'b0, 1'b1, 3'd2, 4'b0000, 3'd4, 1'b0, 1'b1, 18'h00000, 24'h000000};
        tab[2]  = '{1'b1, 1'b1, 3'd2, 4'b0100, 3'd2, 1'b1, 1'b0, 18'h3FFFD, 24'h000000};
        for (int i = 3; i <= 9; i++)
            tab[i] = '{1'b1, 1'b0, 3'd0, 4'b0100, 3'd2, 1'b1, 1'b0, 18'h3FFFD, 24'h000000};
        tab[10] = '{1'b1, 1'b0, 3'd0, 4'b0100, 3'd2, 1'b0, 1'b1, 18'h3FFFF, 24'h000000};
        tab[11] = '{1'b1, 1'b0, 3'd0, 4'b0100, 3'd2, 1'b0, 1'b1, 18'h3FFFF, 24'h222222};
        tab[12] = '{1'b1, 1'b1, 3'd7, 4'b0000, 3'd4, 1'b0, 1'b1, 18'h00000, 24'h222222};
        tab[13] = '{1'b1, 1'b0, 3'd0, 4'b0000, 3'd4, 1'b0, 1'b1, 18'h00000, 24'h000000};

        for (int i = 0; i < 14; i++) begin
            rst_n     = tab[i].rst_n;
            sel_valid = tab[i].vld;
            sel_idx   = tab[i].idx;
            model_edge();
            edge1();
            chk($sformatf("t%0d_ena", i),   32'(ena_o),      32'(tab[i].ena));
            chk($sformatf("t%0d_act", i),   32'(active_idx), 32'(tab[i].act));
            chk($sformatf("t%0d_busy", i),  32'(busy),       32'(tab[i].busy));
            chk($sformatf("t%0d_rdy", i),   32'(sel_ready),  32'(tab[i].rdy));
            chk($sformatf("t%0d_iwo", i),   32'(iw_o),       32'(tab[i].iwo));
            chk($sformatf("t%0d_ow", i),    32'(ow_o),       32'(tab[i].ow));
        end
        sel_valid = 1'b0;

        // Backpressure: request for slot 1 held through slot 0's hold window.
        sel_valid = 1'b1; sel_idx = 3'd0;
        cyc();
        sel_idx = 3'd1;
        repeat (8) cyc();
        chk("bp_still_slot0", 32'(active_idx), 32'd0);
        chk("bp_run_ready",   32'(sel_ready),  32'd1);
        cyc();
        chk("bp_slot1", 32'(active_idx), 32'd1);
        chk("bp_busy",  32'(busy),       32'd1);
        sel_valid = 1'b0;
        repeat (8) cyc();
        chk("bp_run", 32'(busy), 32'd0);

        // Same-slot reselect forces a full re-reset with enable held.
        sel_valid = 1'b1; sel_idx = 3'd1;
        cyc();
        sel_valid = 1'b0;
        chk("rs_busy0", 32'(busy), 32'd1);
        chk("rs_ena0",  32'(ena_o), 32'b0010);
        repeat (7) begin
            cyc();
            chk("rs_ena",  32'(ena_o),   32'b0010);
            chk("rs_busy", 32'(busy),    32'd1);
            chk("rs_rstb", 32'(iw_o[1]), 32'd0);
        end
        cyc();
        chk("rs_run", 32'(busy), 32'd0);

        // Switch slot 0 -> 3 and then disable.
        ow_i = {$urandom, $urandom, $urandom};
        sel_valid = 1'b1; sel_idx = 3'd0;
        cyc();
        sel_valid = 1'b0;
        repeat (8) cyc();
        chk("sw_ena0", 32'(ena_o), 32'b0001);
        sel_valid = 1'b1; sel_idx = 3'd3;
        cyc();
        sel_valid = 1'b0;
        chk("sw_ena3", 32'(ena_o), 32'b1000);
        repeat (9) cyc();
        chk("sw_ow3", 32'(ow_o), 32'(ow_i[3*24 +: 24]));
        sel_valid = 1'b1; sel_idx = 3'd7;
        cyc();
        sel_valid = 1'b0;
        chk("dis_ena", 32'(ena_o), 32'd0);
        chk("dis_act", 32'(active_idx), 32'd4);
        cyc();
        chk("dis_ow", 32'(ow_o), 32'd0);

        // Reset asserted in the middle of HOLD.
        sel_valid = 1'b1; sel_idx = 3'd2;
        cyc();
        sel_valid = 1'b0;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mr_busy",  32'(busy),       32'd0);
        chk("mr_ena",   32'(ena_o),      32'd0);
        chk("mr_act",   32'(active_idx), 32'd4);
        chk("mr_rdy",   32'(sel_ready),  32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            sel_valid = ($urandom_range(0, 3) == 0);
            sel_idx   = 3'($urandom_range(0, 7));
            iw_i      = 18'($urandom);
            ow_i      = {$urandom, $urandom, $urandom};
            cyc();
        end
        rst_n = 1'b0; sel_valid = 1'b0;

        // Single-slot instance with a one-cycle hold.
        repeat (2) edge1();
        chk("sm_rst_act", 32'(s_active), 32'd1);
        chk("sm_rst_ena", 32'(s_ena_o),  32'd0);
        chk("sm_rst_ow",  32'(s_ow_o),   32'd0);
        s_rst_n = 1'b1; s_sel_valid = 1'b1; s_sel_idx = 1'b0;
        edge1();
        s_sel_valid = 1'b0;
        chk("sm_hold_busy", 32'(s_busy),      32'd1);
        chk("sm_hold_ena",  32'(s_ena_o),     32'd1);
        chk("sm_hold_act",  32'(s_active),    32'd0);
        chk("sm_hold_iw",   32'(s_iw_o),      32'h3FFFD);
        chk("sm_hold_rdy",  32'(s_sel_ready), 32'd0);
        edge1();
        chk("sm_run_busy", 32'(s_busy), 32'd0);
        chk("sm_run_iw",   32'(s_iw_o), 32'h3FFFF);
        chk("sm_run_ow0",  32'(s_ow_o), 32'd0);
        edge1();
        chk("sm_run_ow", 32'(s_ow_o), 32'hABCDEF);
        s_sel_valid = 1'b1; s_sel_idx = 1'b1;
        edge1();
        s_sel_valid = 1'b0;
        chk("sm_idle_ena", 32'(s_ena_o),  32'd0);
        chk("sm_idle_act", 32'(s_active), 32'd1);
        chk("sm_idle_iw",  32'(s_iw_o),   32'd0);
        chk("sm_idle_ow1", 32'(s_ow_o),   32'hABCDEF);
        edge1();
        chk("sm_idle_ow2", 32'(s_ow_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
